// File: rtl/sq_norm_pkg.sv
// -----------------------------------------------------------------------------
// sq_norm_pkg
// Shared widths, types and FSM encoding for the squarer output normalizer.
// MOD_LEN comes from `MOD_LEN_DEF (1024 unless defined on the command line).
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

package sq_norm_pkg;

    localparam int MOD_LEN            = `MOD_LEN_DEF;
    localparam int WORD_LEN           = 16;
    localparam int BIT_LEN            = 17;
    localparam int FIELD_LEN          = 32;
    localparam int REDUNDANT_ELEMENTS = 2;
    localparam int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;
    localparam int SQ_OUT_BITS        = NUM_ELEMENTS * WORD_LEN * 2;

    typedef logic [BIT_LEN-1:0]  coeff_t;
    typedef logic [WORD_LEN-1:0] digit_t;
    typedef logic [1:0]          carry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } norm_state_e;

endpackage

// File: rtl/sq_norm_digit.sv
// -----------------------------------------------------------------------------
// sq_norm_digit
// One carry-resolve step: adds the incoming carry to a 17-bit coefficient and
// splits the 18-bit sum into a canonical 16-bit digit and a 2-bit carry.
// Ports:
//   coeff_i : redundant coefficient (low BIT_LEN bits)
//   carry_i : carry from the previous digit (<= 2)
//   digit_o : canonical digit
//   carry_o : carry into the next digit (<= 2)
// -----------------------------------------------------------------------------
module sq_norm_digit
    import sq_norm_pkg::*;
(
    input  coeff_t coeff_i,
    input  carry_t carry_i,
    output digit_t digit_o,
    output carry_t carry_o
);

    logic [BIT_LEN:0] sum;

    assign sum     = {1'b0, coeff_i} + {{(BIT_LEN - 1){1'b0}}, carry_i};
    assign digit_o = sum[WORD_LEN-1:0];
    assign carry_o = sum[BIT_LEN:WORD_LEN];

endmodule

// File: rtl/sq_out_normalizer.sv
// -----------------------------------------------------------------------------
// sq_out_normalizer
// Converts the squarer's redundant coefficients into a canonical integer,
// resolving DIGITS_PER_CYCLE carries per clock, and hands the result to the
// host through a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for sq_valid
// RUN   | resolving one group of D coefficients per cycle
// DONE  | result presented; waiting for res_ready (bypass to RUN allowed)
//
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   sq_valid, sq_in     : input pulse and coefficient bus (32-bit fields)
//   busy                : state != IDLE
//   res_valid/res_ready : result handshake
//   result, res_carry   : canonical digits and final carry out
//   lost                : sticky, an input pulse was dropped
//   fmt_err             : sticky, a captured coefficient had bits above BIT_LEN
// Optional feature macro: SQ_NORM_FMT_CHECK_EN (format check on capture).
// -----------------------------------------------------------------------------
module sq_out_normalizer
    import sq_norm_pkg::*;
#(
    parameter int DIGITS_PER_CYCLE = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             sq_valid,
    input  logic [SQ_OUT_BITS-1:0]           sq_in,
    output logic                             busy,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
    output logic [1:0]                       res_carry,
    output logic                             lost,
    output logic                             fmt_err
);

    localparam int D            = DIGITS_PER_CYCLE;
    localparam int K            = (NUM_ELEMENTS + D - 1) / D;
    localparam int PAD_ELEMENTS = K * D;
    // Number of real coefficients in the final group; stages above it are pad.
    localparam int LAST_VALID   = NUM_ELEMENTS - (K - 1) * D;
    localparam int CNT_W        = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(K - 1);

    // Both registers are shift registers padded to K*D entries so that the
    // active group always sits at the low end of coeff_q, and finished digits
    // enter at the top of work_q and walk down into place.
    logic [PAD_ELEMENTS*BIT_LEN-1:0]  coeff_q, coeff_d, coeff_cap;
    logic [PAD_ELEMENTS*WORD_LEN-1:0] work_q, work_d;
    carry_t                           carry_q, carry_d;
    carry_t                           res_carry_q, res_carry_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    norm_state_e                      state_q, state_d;
    logic                             lost_q, lost_d;
    logic                             capture;
    logic                             last_grp;
    logic [D*WORD_LEN-1:0]            grp_digits;
    carry_t                           chain_out;

    assign last_grp = (cnt_q == '0);

    for (genvar i = 0; i < D; i++) begin : g_chain
        carry_t c_in;
        carry_t c_out;
        digit_t dig_raw;
        carry_t car_raw;

        if (i == 0) begin : g_first
            assign c_in = carry_q;
        end else begin : g_next
            assign c_in = g_chain[i-1].c_out;
        end

        sq_norm_digit u_digit (
            .coeff_i (coeff_q[i*BIT_LEN +: BIT_LEN]),
            .carry_i (c_in),
            .digit_o (dig_raw),
            .carry_o (car_raw)
        );

        // Pad stages of the last group must pass the carry through untouched,
        // otherwise the final carry would be absorbed into non-existent digits.
        if (i >= LAST_VALID) begin : g_pad
            assign grp_digits[i*WORD_LEN +: WORD_LEN] = last_grp ? '0 : dig_raw;
            assign c_out = last_grp ? c_in : car_raw;
        end else begin : g_live
            assign grp_digits[i*WORD_LEN +: WORD_LEN] = dig_raw;
            assign c_out = car_raw;
        end
    end

    assign chain_out = g_chain[D-1].c_out;

    always_comb begin
        coeff_cap = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            coeff_cap[j*BIT_LEN +: BIT_LEN] = sq_in[j*FIELD_LEN +: BIT_LEN];
        end
    end

    always_comb begin
        state_d     = state_q;
        coeff_d     = coeff_q;
        work_d      = work_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        res_carry_d = res_carry_q;
        lost_d      = lost_q;
        capture     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sq_valid) begin
                    capture = 1'b1;
                end
            end
            RUN: begin
                coeff_d = coeff_q >> (D * BIT_LEN);
                work_d  = work_q >> (D * WORD_LEN);
                work_d[PAD_ELEMENTS*WORD_LEN-1 -: D*WORD_LEN] = grp_digits;
                carry_d = chain_out;
                if (last_grp) begin
                    res_carry_d = chain_out;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (sq_valid) begin
                    lost_d = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                    if (sq_valid) begin
                        capture = 1'b1;
                    end
                end else if (sq_valid) begin
                    lost_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            coeff_d = coeff_cap;
            carry_d = '0;
            cnt_d   = CNT_LOAD;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            coeff_q     <= '0;
            work_q      <= '0;
            carry_q     <= '0;
            cnt_q       <= '0;
            res_carry_q <= '0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            coeff_q     <= coeff_d;
            work_q      <= work_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_carry_q <= res_carry_d;
            lost_q      <= lost_d;
        end
    end

`ifdef SQ_NORM_FMT_CHECK_EN
    logic fmt_hit;
    logic fmt_err_q, fmt_err_d;

    always_comb begin
        fmt_hit = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            fmt_hit = fmt_hit | (|sq_in[j*FIELD_LEN+BIT_LEN +: FIELD_LEN-BIT_LEN]);
        end
    end

    always_comb begin
        fmt_err_d = fmt_err_q | (capture & fmt_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_err_q <= 1'b0;
        end else begin
            fmt_err_q <= fmt_err_d;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    // Upper field bits are deliberately ignored in this build.
    logic unused_sq_hi;

    always_comb begin
        unused_sq_hi = 1'b0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            unused_sq_hi = unused_sq_hi ^ (^sq_in[j*FIELD_LEN+BIT_LEN +: FIELD_LEN-BIT_LEN]);
        end
    end

    assign fmt_err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign result    = work_q[NUM_ELEMENTS*WORD_LEN-1:0];
    assign res_carry = res_carry_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_sq_out_normalizer.sv
module tb_sq_out_normalizer;
    import sq_norm_pkg::*;

    localparam int D  = 4;
    localparam int K  = (NUM_ELEMENTS + D - 1) / D;
    localparam int RW = NUM_ELEMENTS * WORD_LEN;

    typedef struct {
        logic [RW-1:0] res;
        logic [1:0]    carry;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   sq_valid;
    logic [SQ_OUT_BITS-1:0] sq_in;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic [RW-1:0]          result;
    logic [1:0]             res_carry;
    logic                   lost;
    logic                   fmt_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sq_out_normalizer #(.DIGITS_PER_CYCLE(D)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sq_valid  (sq_valid),
        .sq_in     (sq_in),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .res_carry (res_carry),
        .lost      (lost),
        .fmt_err   (fmt_err)
    );

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain weighted sum of the low 17 bits of each field.
    function automatic exp_t model(input logic [SQ_OUT_BITS-1:0] s);
        logic [RW+1:0] acc;
        logic [RW+1:0] term;
        exp_t          e;
        acc = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            term       = '0;
            term[16:0] = s[j*32 +: 17];
            acc        = acc + (term << (16 * j));
        end
        e.res   = acc[RW-1:0];
        e.carry = acc[RW+1:RW];
        return e;
    endfunction

    function automatic logic [SQ_OUT_BITS-1:0] rand_stim();
        logic [SQ_OUT_BITS-1:0] s;
        s = '0;
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            s[j*32 +: 32] = 32'($urandom_range(0, 32'h1FFFF));
        end
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send(input logic [SQ_OUT_BITS-1:0] stim);
        sq_in    = stim;
        sq_valid = 1'b1;
        sb.push_back(model(stim));
        @(posedge clk);
        @(negedge clk);
        sq_valid = 1'b0;
    endtask

    // exp_lat = number of clock edges still expected before res_valid (-1: skip).
    task automatic wait_result(input string tag, input int exp_lat, output exp_t e);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, RW'(res_valid), RW'(1));
        if (exp_lat >= 0) chk({tag, "_latency"}, RW'(n), RW'(exp_lat));
        chk({tag, "_sb_depth"}, RW'(sb.size()), RW'(1));
        e.res   = '0;
        e.carry = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_carry"}, RW'(res_carry), RW'(e.carry));
        end
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_valid_fall"}, RW'(res_valid), RW'(0));
        chk({tag, "_busy_fall"}, RW'(busy), RW'(0));
    endtask

    initial begin
        logic [SQ_OUT_BITS-1:0] stim;
        exp_t                   e;
        exp_t                   e_x;

        reset_n   = 1'b0;
        sq_valid  = 1'b0;
        res_ready = 1'b0;
        sq_in     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", RW'(busy), RW'(0));
        chk("rst_valid", RW'(res_valid), RW'(0));
        chk("rst_result", result, '0);
        chk("rst_carry", RW'(res_carry), RW'(0));
        chk("rst_lost", RW'(lost), RW'(0));
        chk("rst_fmt", RW'(fmt_err), RW'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // All-zero coefficients
        send('0);
        chk("zero_busy", RW'(busy), RW'(1));
        wait_result("zero", K, e);
        handshake("zero");

        // c0 = 0x1FFFF
        stim         = '0;
        stim[31:0]   = 32'h0001_FFFF;
        send(stim);
        wait_result("c0max", K, e);
        chk("c0max_d0", RW'(result[15:0]), RW'(16'hFFFF));
        chk("c0max_d1", RW'(result[31:16]), RW'(16'h0001));
        handshake("c0max");

        // Full ripple across every group boundary
        for (int j = 0; j < NUM_ELEMENTS; j++) stim[j*32 +: 32] = 32'h0000_FFFF;
        stim[31:0] = 32'h0001_0000;
        send(stim);
        wait_result("ripple", K, e);
        chk("ripple_res_zero", result, '0);
        chk("ripple_carry1", RW'(res_carry), RW'(1));
        handshake("ripple");

        // All coefficients at maximum
        for (int j = 0; j < NUM_ELEMENTS; j++) stim[j*32 +: 32] = 32'h0001_FFFF;
        send(stim);
        wait_result("allmax", K, e);
        handshake("allmax");

        // Random patterns
        for (int r = 0; r < 3; r++) begin
            send(rand_stim());
            wait_result("rand", K, e);
            handshake("rand");
        end

        // Backpressure then same-cycle handshake + new input (bypass)
        send(rand_stim());
        wait_result("bp", K, e_x);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold_result", result, e_x.res);
            chk("bp_hold_valid", RW'(res_valid), RW'(1));
        end
        stim      = rand_stim();
        res_ready = 1'b1;
        send(stim);
        res_ready = 1'b0;
        chk("bypass_busy", RW'(busy), RW'(1));
        chk("bypass_valid_low", RW'(res_valid), RW'(0));
        wait_result("bypass", K, e);
        chk("bypass_lost", RW'(lost), RW'(0));
        handshake("bypass");

        // Dropped pulse during RUN
        send(rand_stim());
        repeat (4) @(negedge clk);
        sq_in    = rand_stim();
        sq_valid = 1'b1;
        @(negedge clk);
        sq_valid = 1'b0;
        chk("drop_lost", RW'(lost), RW'(1));
        wait_result("drop", K - 5, e);
        handshake("drop");

        // Reset mid-run
        send(rand_stim());
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", RW'(busy), RW'(0));
        chk("midrst_valid", RW'(res_valid), RW'(0));
        chk("midrst_result", result, '0);
        chk("midrst_carry", RW'(res_carry), RW'(0));
        chk("midrst_lost", RW'(lost), RW'(0));
        if (sb.size() > 0) void'(sb.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", RW'(busy), RW'(0));
        send(rand_stim());
        wait_result("postrst", K, e);
        handshake("postrst");

        // Format check: bit 17 of field 3
        stim          = '0;
        stim[3*32 +: 32] = 32'h0002_0000;
        stim[0 +: 32]    = 32'h0000_1234;
        send(stim);
`ifdef SQ_NORM_FMT_CHECK_EN
        chk("fmt_err_set", RW'(fmt_err), RW'(1));
`else
        chk("fmt_err_tied", RW'(fmt_err), RW'(0));
`endif
        wait_result("fmt", K, e);
        chk("fmt_digit3", RW'(result[63:48]), RW'(0));
        handshake("fmt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
